// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants for the mux scan controller: state encodings and default sizing.
package mux_scan_ctrl_pkg;
  localparam int DEF_N_SAMPLES = 4;
  localparam int DEF_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_e;
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan request/result bundle between a requester (master) and the scan controller (slave).
interface mux_scan_ctrl_if
  import mux_scan_ctrl_pkg::*;
#(
  parameter int N_SAMPLES = DEF_N_SAMPLES
);
  logic                 start;
  logic                 z;
  logic                 select;
  logic                 busy;
  logic                 done;
  logic [N_SAMPLES-1:0] result;

  modport master (output start, z, input select, busy, done, result);
  modport slave  (input start, z, output select, busy, done, result);
endinterface

// File: rtl/mux_scan_ctrl_scan_counter.sv
// Sample-step counter with synchronous clear/enable and a terminal flag on the last step.
module mux_scan_ctrl_scan_counter
  import mux_scan_ctrl_pkg::*;
#(
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt <= '0;
    else if (en)       cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == CNT_W'(N_SAMPLES - 1));
endmodule

// File: rtl/mux_scan_ctrl.sv
// Drives the 2:1 mux select with 0,1,0,1... for N_SAMPLES steps, packs the sampled z
// into result, then pulses done for one cycle.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_ctrl_if.slave bus
);
  state_e               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 tc, cnt_clr, cnt_en;
  logic                 sel_q, sel_nxt;
  logic [N_SAMPLES-1:0] res_q, res_nxt;

  mux_scan_ctrl_scan_counter #(.N_SAMPLES(N_SAMPLES), .CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (cnt),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    sel_nxt   = 1'b0;
    res_nxt   = res_q;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_SCAN;
          cnt_clr   = 1'b1;
          res_nxt   = '0;
        end
      end
      ST_SCAN: begin
        cnt_en = 1'b1;
        // z reflects the select driven during the cycle now ending
        for (int i = 0; i < N_SAMPLES; i++)
          if (cnt == CNT_W'(i)) res_nxt[i] = bus.z;
        if (tc) state_nxt = ST_DONE;
        else begin
          state_nxt = ST_SCAN;
          sel_nxt   = ~sel_q;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q <= 1'b0;
      res_q <= '0;
    end else begin
      sel_q <= sel_nxt;
      res_q <= res_nxt;
    end
  end

  assign bus.select = sel_q;
  assign bus.result = res_q;
  assign bus.busy   = (state == ST_SCAN);
  assign bus.done   = (state == ST_DONE);
endmodule
